// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU instruction-memory path.
package mips_cpu_pkg;

   // Instruction memory word address and instruction word
   typedef logic [9:0]  im_addr_t;
   typedef logic [31:0] inst_t;

   localparam inst_t ZERO = '0;

   // Default number of back-to-back fetch grants tolerated while the loader waits
   localparam int IM_ARB_STARVE_LIMIT = 4;

   // Instruction memory arbiter priority state
   typedef enum logic {
      FETCH_PRI = 1'b0,
      LOAD_PRI  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/im_arb.sv
// Instruction memory arbiter: shares one single-port instruction memory
// between the fetch stage and the loader/debug port. Fetch normally wins,
// but the loader is promoted after STARVE_LIMIT consecutive losses.
module im_arb
   import mips_cpu_pkg::*;
#(
   parameter int STARVE_LIMIT = IM_ARB_STARVE_LIMIT
)(
   input  logic       cpu_clk_50M,
   input  logic       cpu_rst,
   // fetch port
   input  logic       f_req,
   input  im_addr_t   f_addr,
   input  logic       f_flush,
   output logic       f_gnt,
   output logic       f_rvalid,
   output inst_t      f_rdata,
   // loader/debug port
   input  logic       l_req,
   input  im_addr_t   l_addr,
   output logic       l_gnt,
   output logic       l_rvalid,
   output inst_t      l_rdata,
   // instruction memory
   output logic       imce,
   output im_addr_t   imaddr,
   input  inst_t      inst
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   arb_state_t state_reg, state_next;
   logic [3:0] starve_cnt_reg, starve_cnt_next;
   logic       resp_valid_reg, resp_valid_next;
   logic       resp_port_reg, resp_port_next;   // 0: fetch, 1: loader
   logic       f_cand, l_cand;

   // Grant selection: tie broken by the current priority state; reset masks all grants
   always_comb begin
      f_gnt  = 1'b0;
      l_gnt  = 1'b0;
      // a flushed fetch request is treated as absent so the loader can take the slot
      f_cand = f_req & ~f_flush & ~cpu_rst;
      l_cand = l_req & ~cpu_rst;
      if (state_reg == LOAD_PRI) begin
         l_gnt = l_cand;
         f_gnt = f_cand & ~l_cand;
      end else begin
         f_gnt = f_cand;
         l_gnt = l_cand & ~f_cand;
      end
   end

   // Next-state: starve counter, priority state and pending response tracking
   always_comb begin
      state_next      = state_reg;
      starve_cnt_next = starve_cnt_reg;
      resp_valid_next = f_gnt | l_gnt;
      resp_port_next  = l_gnt;

      // counter only accumulates fetch wins while the loader keeps waiting
      if (!l_req || l_gnt) begin
         starve_cnt_next = 4'd0;
      end else if (state_reg == FETCH_PRI && f_gnt && starve_cnt_reg != LIMIT) begin
         starve_cnt_next = starve_cnt_reg + 4'd1;
      end

      case (state_reg)
         FETCH_PRI: begin
            if (starve_cnt_next == LIMIT) begin
               state_next = LOAD_PRI;
            end
         end
         LOAD_PRI: begin
            // one loader win (or the loader giving up) restores fetch priority
            if (l_gnt || !l_req) begin
               state_next = FETCH_PRI;
            end
         end
         default: state_next = FETCH_PRI;
      endcase
   end

   // Memory drive and response steering; responses are masked during reset
   always_comb begin
      imce     = f_gnt | l_gnt;
      imaddr   = '0;
      if (l_gnt) begin
         imaddr = l_addr;
      end else if (f_gnt) begin
         imaddr = f_addr;
      end
      // a flush in the response cycle discards the returning fetch word
      f_rvalid = resp_valid_reg & ~resp_port_reg & ~f_flush & ~cpu_rst;
      l_rvalid = resp_valid_reg &  resp_port_reg & ~cpu_rst;
      f_rdata  = f_rvalid ? inst : ZERO;
      l_rdata  = l_rvalid ? inst : ZERO;
   end

   // State registers with asynchronous reset
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_reg      <= FETCH_PRI;
         starve_cnt_reg <= 4'd0;
         resp_valid_reg <= 1'b0;
         resp_port_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         starve_cnt_reg <= starve_cnt_next;
         resp_valid_reg <= resp_valid_next;
         resp_port_reg  <= resp_port_next;
      end
   end

endmodule

// File: doc/im_arb.md
IM_ARB -- requirements
Module: im_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, max consecutive fetch grants while loader is requesting (range 1..15).
REQ-002 cpu_clk_50M  input  1  system clock; all state updates on rising edge.
REQ-003 cpu_rst  input  1  asynchronous, active-high reset.
REQ-004 f_req  input  1  fetch port read request.
REQ-005 f_addr  input  im_addr_t  fetch word address.
REQ-006 f_flush  input  1  fetch pipeline flush; kills any in-flight fetch response.
REQ-007 f_gnt  output  1  fetch request accepted this cycle.
REQ-008 f_rvalid  output  1  fetch read data valid.
REQ-009 f_rdata  output  inst_t  fetch read data.
REQ-010 l_req  input  1  loader/debug port read request.
REQ-011 l_addr  input  im_addr_t  loader word address.
REQ-012 l_gnt  output  1  loader request accepted this cycle.
REQ-013 l_rvalid  output  1  loader read data valid.
REQ-014 l_rdata  output  inst_t  loader read data.
REQ-015 imce  output  1  instruction memory enable.
REQ-016 imaddr  output  im_addr_t  instruction memory address.
REQ-017 inst  input  inst_t  instruction memory read data, valid one cycle after imce.

Function
REQ-018 At most one of f_gnt/l_gnt SHALL be high per cycle; gnt is combinational from req and arbiter state.
REQ-019 In a grant cycle: imce=1, imaddr=granted port address; otherwise imce=0, imaddr=0.
REQ-020 Read latency SHALL be exactly 1: cycle after grant, granted port's rvalid=1 and rdata=inst; never both rvalid high.
REQ-021 rdata SHALL be 0 whenever the corresponding rvalid is 0.
REQ-022 Arbiter states: FETCH_PRI (fetch wins ties) and LOAD_PRI (loader wins ties); a sole requester is always granted in either state.
REQ-023 FETCH_PRI: each fetch grant while l_req=1 increments starve counter; counter reaching STARVE_LIMIT -> LOAD_PRI next cycle.
REQ-024 LOAD_PRI: first loader grant -> FETCH_PRI, counter cleared; l_req dropping without grant -> FETCH_PRI, counter cleared.
REQ-025 Starve counter SHALL clear whenever l_req=0 or a loader grant occurs; saturates at STARVE_LIMIT, no wrap.
REQ-026 f_flush=1 in the response cycle of a fetch SHALL force f_rvalid=0 that cycle.
REQ-027 f_flush=1 in a fetch grant cycle SHALL suppress f_gnt, imce driven only if loader is granted instead.
REQ-028 f_flush SHALL NOT affect loader grants or loader responses.
REQ-029 Back-to-back grants every cycle SHALL be supported (full throughput, no bubbles).

Reset
REQ-030 cpu_rst=1 SHALL immediately force: state FETCH_PRI, counter 0, pending-response flags 0, all rvalid 0, rdata 0, gnt 0, imce 0, imaddr 0.
REQ-031 A grant issued in the cycle reset asserts SHALL produce no rvalid after reset deasserts.
REQ-032 First grant possible in first clock edge cycle after cpu_rst deasserts.

Structure
REQ-033 im_addr_t, inst_t, ZERO and a new arb_state_t enum SHALL live in mips_cpu_pkg; STARVE_LIMIT default as package constant IM_ARB_STARVE_LIMIT.
REQ-034 Single module, no sub-modules; registers: state, starve counter (4 bits), resp_valid, resp_port.

Verification
REQ-035 f_req=1 only, f_addr=0x010 -> f_gnt=1, imce=1, imaddr=0x010; next cycle f_rvalid=1, f_rdata=mem[0x010].
REQ-036 f_req and l_req held high, STARVE_LIMIT=4 -> grant sequence F,F,F,F,L,F,F,F,F,L repeating.
REQ-037 Fetch granted at cycle N, f_flush=1 at N+1 -> f_rvalid=0 at N+1; loader response in same window unaffected.
REQ-038 Alternating single-port requests every cycle -> one grant per cycle, no idle cycles, rvalid on matching port.
REQ-039 cpu_rst asserted mid-transfer (cycle after grant) -> all outputs 0 immediately; no rvalid after release.
REQ-040 l_req dropped while in LOAD_PRI -> state returns FETCH_PRI, counter 0, next f_req granted same cycle.
